dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage load/store interface.
- Accepts a MemRead/MemWrite request with addr/wdata, performs it after a programmable latency, and holds the pipeline via stall until done.
- Replaces the zero-latency data memory so the pipeline can be exercised against slow memory.
- Sits between EXMEM outputs (Mreg, ALUreg, WriteDataOut) and the MEMWB inputs (Memout); stall feeds the pipeline's global freeze.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 45 ++++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_pkg                                                     |
// | Description : Shared FSM encoding, limits and helpers for dmem_responder.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package dmem_pkg;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_array                                                   |
// | Description : Single-port DEPTH x 32 word array, sync write, registered    |
// |               read port that can be forced to zero.                        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module dmem_array #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic                 clr_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    // Storage is deliberately left out of reset so it maps onto block RAM.
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : MEM-stage load/store responder with programmable latency;    |
// |               holds the pipeline through stall until the access is done.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        ready,
    output logic        err
);

    localparam int               ADDR_BITS = addr_bits(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_latency
            $error("dmem_responder: LATENCY=%0d outside 1..%0d", LATENCY, LAT_MAX);
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("dmem_responder: DEPTH=%0d is not a power of two >= 2", DEPTH);
        end
    endgenerate

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               rd_q;
    logic               wr_q;
    logic               ready_q;
    logic               err_q;

    logic               w_req;
    logic               w_access;
    logic               w_illegal;
    logic               w_mem_en;
    logic               w_rd_clr;

    assign w_req = MemRead | MemWrite;

    assign w_illegal = (addr_q[1:0] != 2'b00)
                     || ({2'b00, addr_q[31:2]} >= 32'(DEPTH))
                     || (rd_q && wr_q);

    assign w_access = (state_q == ST_WAIT) && (cnt_q == '0);

    // rst gating drops a write whose access edge coincides with reset.
    assign w_mem_en = w_access && !w_illegal && !rst;
    assign w_rd_clr = w_access && w_illegal && rd_q;

    assign stall = ((state_q == ST_IDLE) && w_req) || (state_q == ST_WAIT);
    assign ready = ready_q;
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rd_q    <= MemRead;
                        wr_q    <= MemWrite;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        err_q   <= w_illegal;
                        state_q <= ST_DONE;
                    end
                end
                // The same instruction is still presented here; never re-accept it.
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_mem_en),
        .we_i    (wr_q),
        .clr_i   (w_rd_clr),
        .addr_i  (addr_q[ADDR_BITS+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                            |
// | Description : Directed plus randomized bench for dmem_responder against a  |
// |               transaction-level memory model.                              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        ready;
    logic        err;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          last_done_cyc = 0;
    int          t_first;

    logic [31:0] ref_mem [int];
    int          written_q [$];
    logic [31:0] model_rdata = 32'h0;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .ready    (ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // A request is legal when it is word aligned, inside the array and not both ops.
    function automatic bit is_legal(input bit rd, input bit wr, input logic [31:0] a);
        return !(rd && wr) && (a % 32'd4 == 32'd0) && ((a / 32'd4) < 32'(DEPTH));
    endfunction

    // One pipeline instruction held by a stalled driver, from first sight to the
    // end of the DONE cycle; returns at the start of the following cycle.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit scramble, input string tag);
        bit          ok;
        logic [31:0] exp_rd;
        ok = is_legal(rd, wr, a);
        if (rd) exp_rd = ok ? ref_mem[int'(a / 32'd4)] : 32'h0;
        else    exp_rd = model_rdata;

        MemRead = rd; MemWrite = wr; addr = a; wdata = d;
        #1 chk_bit({tag, ":stall_c0"}, stall, 1'b1);
        for (int c = 1; c <= LATENCY; c++) begin
            @(negedge clk);
            chk_bit({tag, ":stall_wait"}, stall, 1'b1);
            chk_bit({tag, ":ready_early"}, ready, 1'b0);
            if (scramble) begin
                MemRead  = 1'($urandom_range(1));
                MemWrite = 1'($urandom_range(1));
                addr     = $urandom;
                wdata    = $urandom;
            end
        end
        @(negedge clk);
        chk_bit({tag, ":ready"}, ready, 1'b1);
        chk_bit({tag, ":err"}, err, !ok);
        chk_bit({tag, ":stall_done"}, stall, 1'b0);
        chk({tag, ":rdata"}, rdata, exp_rd);
        last_done_cyc = cyc;
        if (ok && wr) ref_mem[int'(a / 32'd4)] = d;
        model_rdata = exp_rd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        MemRead = 1'b0; MemWrite = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1 chk_bit("idle:stall", stall, 1'b0);
            chk_bit("idle:ready", ready, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk_bit("reset:ready", ready, 1'b0);
        chk_bit("reset:err", err, 1'b0);
        chk_bit("reset:stall", stall, 1'b0);
        chk("reset:rdata", rdata, 32'h0);
        MemRead = 1'b1;
        #1 chk_bit("reset:stall_follows", stall, 1'b1);
        MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Store then load
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "st10");
        idle(1);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "ld10");

        // Back-to-back loads, no gap between instructions
        txn(1'b0, 1'b1, 32'h0, 32'h11, 1'b0, "st0");
        txn(1'b0, 1'b1, 32'h4, 32'h22, 1'b0, "st4");
        txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "b2b_ld0");
        t_first = last_done_cyc;
        txn(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, "b2b_ld4");
        chk("b2b:ready_spacing", 32'(last_done_cyc - t_first), 32'd4);

        // Illegal requests
        txn(1'b1, 1'b0, 32'h6, 32'h0, 1'b0, "misaligned_ld");
        txn(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, "ld4_after_err");
        txn(1'b0, 1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 1'b0, "oor_st");
        txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "ld0_after_oor");
        txn(1'b0, 1'b1, 32'h8, 32'h33, 1'b0, "st8");
        txn(1'b1, 1'b1, 32'h8, 32'h99, 1'b0, "both_ops");
        txn(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, "ld8_unchanged");

        // Reset on the access edge of an in-flight write
        txn(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, "st20_pre");
        MemRead = 1'b0; MemWrite = 1'b1; addr = 32'h20; wdata = 32'h12345678;
        #1 chk_bit("rstwait:stall_c0", stall, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_bit("rstwait:ready", ready, 1'b0);
        chk_bit("rstwait:err", err, 1'b0);
        chk("rstwait:rdata", rdata, 32'h0);
        chk_bit("rstwait:stall_req", stall, 1'b1);
        MemWrite = 1'b0;
        #1 chk_bit("rstwait:stall_noreq", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_rdata = 32'h0;
        txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "ld20_after_rst");

        written_q = '{0, 1, 2, 4, 8};

        // Randomized mix, with inputs scrambled while the responder is busy
        for (int i = 0; i < 60; i++) begin
            int          kind;
            int          idx;
            logic [31:0] a;
            logic [31:0] d;
            kind = int'($urandom_range(9));
            d    = $urandom;
            if (kind < 4) begin
                idx = int'($urandom_range(DEPTH - 1));
                written_q.push_back(idx);
                txn(1'b0, 1'b1, 32'(idx) << 2, d, 1'b1, "rnd_st");
            end else if (kind < 7) begin
                idx = written_q[$urandom_range(written_q.size() - 1)];
                txn(1'b1, 1'b0, 32'(idx) << 2, d, 1'b1, "rnd_ld");
            end else if (kind == 7) begin
                a = (32'($urandom_range(DEPTH - 1)) << 2) | 32'($urandom_range(3, 1));
                if ($urandom_range(1) == 0) txn(1'b1, 1'b0, a, d, 1'b1, "rnd_mis_ld");
                else                        txn(1'b0, 1'b1, a, d, 1'b1, "rnd_mis_st");
            end else if (kind == 8) begin
                a = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
                if ($urandom_range(1) == 0) txn(1'b1, 1'b0, a, d, 1'b1, "rnd_oor_ld");
                else                        txn(1'b0, 1'b1, a, d, 1'b1, "rnd_oor_st");
            end else begin
                idx = written_q[$urandom_range(written_q.size() - 1)];
                txn(1'b1, 1'b1, 32'(idx) << 2, d, 1'b1, "rnd_both");
            end
            if ($urandom_range(2) == 0) idle(1);
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
